seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 149 ++++++++++++++
 tb/tb_seq_alu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with handshake, conditional writeback and iterative multiplier
//
// Purpose: accepts one operation per request (ADD, SUB, NAND, XOR, MUL), computes
// the result (single cycle, or WIDTH shift-add cycles for MUL), gates writeback on
// the flags captured at acceptance and optionally updates the carry/zero flags.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request present            in_ready  block idle and able to accept
//   a, b       operands (WIDTH bits)      op        000 ADD, 001 SUB, 010 NAND, 011 XOR, 100 MUL
//   flag_ctl   [3] cond_c [2] cond_z [1] set_z [0] set_c
//   out_valid  result present             out_ready consumer accepts the result
//   result     operation result           write_en  writeback permission for result
//   carry      carry flag register        zero      zero flag register

module seq_alu #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [3:0]       flag_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             write_en,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q;       // multiplicand
  logic [2*WIDTH-1:0] prod;      // {partial high half, remaining multiplier bits}
  logic [3:0]         ctl_q;
  logic               c_acc;     // carry at acceptance
  logic               z_acc;     // zero at acceptance

  // Single-cycle ops return {carry_new, result}. MUL never reaches here when
  // enabled; with MUL_EN=0 it falls into the ADD default.
  function automatic logic [WIDTH:0] fast_op(input logic [2:0] f_op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    case (f_op)
      3'b001:  r = {x < y, x - y};
      3'b010:  r = {1'b0, ~(x & y)};
      3'b011:  r = {1'b0, x ^ y};
      default: r = {1'b0, x} + {1'b0, y};
    endcase
    return r;
  endfunction

  function automatic logic we_calc(input logic [3:0] ctl, input logic c, input logic z);
    return !((ctl[3] && !c) || (ctl[2] && !z));
  endfunction

  logic               is_mul;
  logic [WIDTH:0]     fast;
  logic               fast_we;
  logic               fast_zero;
  logic [WIDTH:0]     acc_add;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_carry;
  logic               mul_we;

  always_comb begin
    is_mul    = (MUL_EN != 0) && (op == 3'b100);
    fast      = fast_op(op, a, b);
    fast_we   = we_calc(flag_ctl, carry, zero);
    fast_zero = (fast[WIDTH-1:0] == '0);
    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole product right.
    acc_add   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_next = {acc_add, prod[WIDTH-1:1]};
    mul_res   = prod_next[WIDTH-1:0];
    mul_carry = |prod_next[2*WIDTH-1:WIDTH];
    mul_we    = we_calc(ctl_q, c_acc, z_acc);
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      result   <= '0;
      write_en <= 1'b0;
      a_q      <= '0;
      prod     <= '0;
      ctl_q    <= '0;
      c_acc    <= 1'b0;
      z_acc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            prod  <= {{WIDTH{1'b0}}, b};
            ctl_q <= flag_ctl;
            c_acc <= carry;
            z_acc <= zero;
            cnt   <= '0;
            if (is_mul) begin
              state <= BUSY;
            end else begin
              state    <= DONE;
              result   <= fast[WIDTH-1:0];
              write_en <= fast_we;
              if (fast_we && flag_ctl[0]) carry <= fast[WIDTH];
              if (fast_we && flag_ctl[1]) zero  <= fast_zero;
            end
          end
        end
        BUSY: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state    <= DONE;
            result   <= mul_res;
            write_en <= mul_we;
            if (mul_we && ctl_q[0]) carry <= mul_carry;
            if (mul_we && ctl_q[1]) zero  <= (mul_res == '0);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against an arithmetic reference model

module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid, in_ready, out_valid, out_ready, write_en, carry, zero;
  logic [15:0] a, b, result;
  logic [2:0]  op;
  logic [3:0]  flag_ctl;

  logic       in_valid_8, in_ready_8, out_valid_8, out_ready_8, write_en_8, carry_8, zero_8;
  logic [7:0] a_8, b_8, result_8;
  logic [2:0] op_8;
  logic [3:0] flag_ctl_8;

  seq_alu #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .flag_ctl(flag_ctl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .write_en(write_en),
    .carry(carry), .zero(zero)
  );

  seq_alu #(.WIDTH(8), .MUL_EN(0)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .a(a_8), .b(b_8), .op(op_8), .flag_ctl(flag_ctl_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .result(result_8), .write_en(write_en_8),
    .carry(carry_8), .zero(zero_8)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic mc, mz;  // model flags for the 16-bit instance

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  task automatic ref_op(input int w, input bit mul_en, input logic [2:0] o,
                        input longint unsigned x, input longint unsigned y,
                        output longint unsigned res, output bit c);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned t;
    if (o == 3'd1) begin
      res = (x - y) & mask; c = (x < y);
    end else if (o == 3'd2) begin
      res = ~(x & y) & mask; c = 0;
    end else if (o == 3'd3) begin
      res = (x ^ y) & mask; c = 0;
    end else if (o == 3'd4 && mul_en) begin
      t = x * y; res = t & mask; c = ((t >> w) != 0);
    end else begin
      t = x + y; res = t & mask; c = ((t >> w) != 0);
    end
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic [3:0] ctl, input int hold, input string tag);
    longint unsigned er;
    bit ec, ewe;
    int lat, exp_lat;
    ref_op(16, 1'b1, o, av, bv, er, ec);
    ewe = !((ctl[3] && !mc) || (ctl[2] && !mz));
    if (ewe && ctl[0]) mc = ec;
    if (ewe && ctl[1]) mz = (er == 0);
    exp_lat = (o == 3'd4) ? 17 : 1;

    check({tag, ".in_ready"}, in_ready, 1);
    a = av; b = bv; op = o; flag_ctl = ctl; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, result, er);
    check({tag, ".write_en"}, write_en, ewe);
    check({tag, ".carry"}, carry, mc);
    check({tag, ".zero"}, zero, mz);

    // Backpressure: DONE must hold while a competing request is offered.
    for (int i = 0; i < hold; i++) begin
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom); flag_ctl = 4'hF;
      in_valid = 1'b1;
      step();
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_ready"}, in_ready, 0);
      check({tag, ".hold_result"}, {result, write_en, carry, zero}, {er[15:0], ewe, mc, mz});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    longint unsigned r;
    bit c;
    logic [2:0]  ro;
    logic [15:0] ra, rb;
    bit seen;

    reset = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0; flag_ctl = 0;
    in_valid_8 = 0; out_ready_8 = 0; a_8 = 0; b_8 = 0; op_8 = 0; flag_ctl_8 = 0;
    mc = 0; mz = 0;
    step();
    step();
    check("reset.ready_valid", {in_ready, out_valid}, 2'b00);
    check("reset.regs", {result, write_en, carry, zero}, 19'd0);
    reset = 1'b0;
    #1;
    check("reset.ready_after", in_ready, 1);

    // Narrow instance without multiplier: MUL acts as ADD, one-cycle latency.
    a_8 = 8'h0F; b_8 = 8'h01; op_8 = 3'b100; flag_ctl_8 = 4'b0000; in_valid_8 = 1'b1;
    step();
    in_valid_8 = 1'b0;
    check("w8.mul_as_add_valid", out_valid_8, 1);
    check("w8.mul_as_add_result", result_8, 8'h10);
    out_ready_8 = 1'b1;
    step();
    out_ready_8 = 1'b0;

    run16(3'd0, 16'hFFFF, 16'h0001, 4'b0011, 0, "add_wrap");
    check("add_wrap.flags_abs", {carry, zero}, 2'b11);

    run16(3'd0, 16'h0001, 16'h0001, 4'b0001, 0, "clear_c");
    run16(3'd1, 16'h0005, 16'h0003, 4'b1001, 0, "sub_cond_blocked");
    check("sub_cond_blocked.abs", {result, write_en, carry}, {16'h0002, 1'b0, 1'b0});
    run16(3'd0, 16'hFFFF, 16'h0001, 4'b0001, 0, "set_c");
    run16(3'd1, 16'h0005, 16'h0003, 4'b1001, 0, "sub_cond_pass");
    check("sub_cond_pass.abs", {result, write_en, carry}, {16'h0002, 1'b1, 1'b0});

    run16(3'd4, 16'h0100, 16'h0100, 4'b0011, 0, "mul_ovf");
    check("mul_ovf.abs", {result, carry}, {16'h0000, 1'b1});
    run16(3'd4, 16'h0003, 16'h0005, 4'b0000, 0, "mul_small");
    check("mul_small.abs", result, 16'h000F);

    run16(3'd2, 16'hF0F0, 16'h0FF0, 4'b0011, 5, "nand_backpressure");
    run16(3'd3, 16'h1234, 16'h1234, 4'b0011, 0, "xor_zero");

    // Reset during the eighth BUSY cycle of a multiply.
    run16(3'd0, 16'hFFFF, 16'h0001, 4'b0011, 0, "preset_flags");
    a = 16'h0007; b = 16'h0009; op = 3'd4; flag_ctl = 4'b0011; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    check("mid_mul_reset.ready_valid", {in_ready, out_valid}, 2'b00);
    check("mid_mul_reset.regs", {result, write_en, carry, zero}, 19'd0);
    reset = 1'b0;
    #1;
    check("mid_mul_reset.ready_after", in_ready, 1);
    mc = 0; mz = 0;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("mid_mul_reset.no_result", seen, 0);

    for (int n = 0; n < 50; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      if ($urandom_range(0, 5) == 0) ra = 16'h0000;
      run16(ro, ra, rb, 4'($urandom), $urandom_range(0, 2), $sformatf("rand%0d_op%0d", n, ro));
    end

    ref_op(16, 1'b1, 3'd4, 64'hFFFF, 64'hFFFF, r, c);
    check("model.mul_max", {r[15:0], c}, {16'h0001, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
